filter_relay_sequencer: RTL

Sequences switching of the external band-filter board and the T/R relay whenever the decoded band or the PTT request changes. It sits between the band decoder's 3-bit `band` output and the filter-board serial interface. It mutes the receiver and holds off the transmitter while the filter word is shifted out, latched and allowed to settle, so relays never hot-switch under RF.

---
 rtl/filter_relay_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/filter_relay_sequencer.sv
// Purpose: sequences band-filter/T-R relay switching; mutes RX and holds TX off while a 16-bit word is shifted, latched, settled.
// Latency: IDLE input change -> rx_mute high in 2 clocks; full sequence MUTE_CYCLES + 33*SHIFT_DIV + SETTLE_CYCLES clocks.
// Backpressure: none; input changes during a sequence are deferred to the end of SETTLE, words are never aborted except by reset.
module filter_relay_sequencer #(
  parameter int MUTE_CYCLES   = 256,
  parameter int SHIFT_DIV     = 16,
  parameter int SETTLE_CYCLES = 61440
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] band_in,
  input  logic       ptt_req,
  output logic       tx_enable,
  output logic       rx_mute,
  output logic       busy,
  output logic [2:0] cur_band,
  output logic       filt_sclk,
  output logic       filt_sdata,
  output logic       filt_latch
);

  localparam int MW = (MUTE_CYCLES   > 1) ? $clog2(MUTE_CYCLES)   : 1;
  localparam int DW = (SHIFT_DIV     > 1) ? $clog2(SHIFT_DIV)     : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [MW-1:0] MUTE_LAST   = MW'(MUTE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SHIFT_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MUTE, SHIFT, LATCH, SETTLE} state_t;

  state_t          state, state_nx;
  logic [MW-1:0]   mute_cnt, mute_cnt_nx;
  logic [DW-1:0]   div_cnt, div_cnt_nx;
  logic [SW-1:0]   settle_cnt, settle_cnt_nx;
  logic [3:0]      bit_idx, bit_idx_nx;
  logic            snap_ptt, snap_ptt_nx;
  logic [2:0]      snap_band, snap_band_nx;
  logic            app_ptt, app_ptt_nx;
  logic [2:0]      cur_band_nx;
  logic            diff_q, diff_nx;
  logic            tx_enable_nx, rx_mute_nx, busy_nx;
  logic            sclk_nx, sdata_nx, latch_nx;

  logic [3:0]      req;
  logic [15:0]     snap_word;
  logic [15:0]     req_word;
  logic [3:0]      idx_dec;

  // 16-bit board word: T/R relay in bit 15, one-hot band filter in bits 7:0
  function automatic logic [15:0] filter_word(input logic ptt, input logic [2:0] band);
    logic [7:0] onehot;
    onehot = 8'b1 << band;
    return {ptt, 7'b0, onehot};
  endfunction

  assign req       = {ptt_req, band_in};
  assign snap_word = filter_word(snap_ptt, snap_band);
  assign req_word  = filter_word(ptt_req, band_in);
  assign idx_dec   = bit_idx - 4'd1;

  // Next-state, counters and registered-output values
  always_comb begin
    state_nx      = state;
    mute_cnt_nx   = mute_cnt;
    div_cnt_nx    = div_cnt;
    settle_cnt_nx = settle_cnt;
    bit_idx_nx    = bit_idx;
    snap_ptt_nx   = snap_ptt;
    snap_band_nx  = snap_band;
    app_ptt_nx    = app_ptt;
    cur_band_nx   = cur_band;
    sclk_nx       = filt_sclk;
    sdata_nx      = filt_sdata;
    latch_nx      = filt_latch;

    case (state)
      IDLE: begin
        if (diff_q) begin
          state_nx                    = MUTE;
          mute_cnt_nx                 = '0;
          {snap_ptt_nx, snap_band_nx} = req;
        end
      end
      MUTE: begin
        if (mute_cnt == MUTE_LAST) begin
          mute_cnt_nx = '0;
          state_nx    = SHIFT;
          bit_idx_nx  = 4'd15;
          div_cnt_nx  = '0;
          sclk_nx     = 1'b0;
          sdata_nx    = snap_word[15];
        end else begin
          mute_cnt_nx = mute_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!filt_sclk) begin
            sclk_nx = 1'b1;
          end else begin
            // data only moves on the falling edge so it is stable across the high phase
            sclk_nx = 1'b0;
            if (bit_idx == 4'd0) begin
              state_nx = LATCH;
              latch_nx = 1'b1;
            end else begin
              bit_idx_nx = idx_dec;
              sdata_nx   = snap_word[idx_dec];
            end
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx    = '0;
          latch_nx      = 1'b0;
          state_nx      = SETTLE;
          settle_cnt_nx = '0;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nx = '0;
          app_ptt_nx    = snap_ptt;
          cur_band_nx   = snap_band;
          if (req != {snap_ptt, snap_band}) begin
            // mute is still held, so go straight to shifting the new word
            state_nx                    = SHIFT;
            {snap_ptt_nx, snap_band_nx} = req;
            bit_idx_nx                  = 4'd15;
            div_cnt_nx                  = '0;
            sclk_nx                     = 1'b0;
            sdata_nx                    = req_word[15];
          end else begin
            state_nx = IDLE;
          end
        end else begin
          settle_cnt_nx = settle_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // compare against the applied values as they will be after this edge
    diff_nx      = (req != {app_ptt_nx, cur_band_nx});
    busy_nx      = (state_nx != IDLE);
    rx_mute_nx   = (state_nx != IDLE);
    tx_enable_nx = (state_nx == IDLE) && app_ptt_nx && ptt_req;
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MUTE;
      mute_cnt   <= '0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      bit_idx    <= '0;
      snap_ptt   <= ptt_req;
      snap_band  <= band_in;
      app_ptt    <= 1'b0;
      cur_band   <= 3'd0;
      diff_q     <= 1'b0;
      tx_enable  <= 1'b0;
      rx_mute    <= 1'b1;
      busy       <= 1'b1;
      filt_sclk  <= 1'b0;
      filt_sdata <= 1'b0;
      filt_latch <= 1'b0;
    end else begin
      state      <= state_nx;
      mute_cnt   <= mute_cnt_nx;
      div_cnt    <= div_cnt_nx;
      settle_cnt <= settle_cnt_nx;
      bit_idx    <= bit_idx_nx;
      snap_ptt   <= snap_ptt_nx;
      snap_band  <= snap_band_nx;
      app_ptt    <= app_ptt_nx;
      cur_band   <= cur_band_nx;
      diff_q     <= diff_nx;
      tx_enable  <= tx_enable_nx;
      rx_mute    <= rx_mute_nx;
      busy       <= busy_nx;
      filt_sclk  <= sclk_nx;
      filt_sdata <= sdata_nx;
      filt_latch <= latch_nx;
    end
  end

endmodule
